motor_cmd_supervisor: RTL and testbench

Parametrised command-conditioning stage that sits between the host command registers and the motor output stage (PWM generator, pattern generator).
- Ramps the PWM command at a configurable slew rate.
- Detects low speed with hysteresis, replacing the single-threshold flag.
- Sequences safe direction reversal: decelerate, then brake, then restart.
- Raises a latched stall fault.
- All outputs are registered.

---
 rtl/motor_cmd_supervisor_pkg.sv | 14 +
 rtl/motor_cmd_supervisor_pwm_ramp.sv | 45 ++++
 rtl/motor_cmd_supervisor.sv | 125 ++++++++++++
 tb/tb_motor_cmd_supervisor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_supervisor_pkg.sv
// Shared types for the motor command supervisor: FSM state encoding.
package motor_pkg;

  localparam int K_STATE_W = 3;

  typedef enum logic [K_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DECEL = 3'd2,
    ST_BRAKE = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

endpackage

// File: rtl/motor_cmd_supervisor_pwm_ramp.sv
// Slew-limited PWM command register: steps toward target on ticks, never wraps.
module pwm_ramp #(
  parameter int K_RES = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             tick,
  input  logic             advance,
  input  logic             force_zero,
  input  logic [K_RES-1:0] step,
  input  logic [K_RES-1:0] target,
  output logic [K_RES-1:0] value
);

  logic [K_RES-1:0] value_nxt;
  logic [K_RES:0]   sum;
  logic [K_RES-1:0] diff;

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    value_nxt = value;
    sum       = {1'b0, value} + {1'b0, step};
    diff      = value - target;
    if (force_zero) begin
      value_nxt = '0;
    end else if (advance) begin
      if (step == '0) begin
        value_nxt = target;
      end else if (tick) begin
        if (value < target) begin
          value_nxt = (sum > {1'b0, target}) ? target : sum[K_RES-1:0];
        end else if (value > target) begin
          value_nxt = (diff <= step) ? target : value - step;
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) value <= '0;
    else       value <= value_nxt;
  end

endmodule

// File: rtl/motor_cmd_supervisor.sv
// Conditions host motor commands: ramped PWM, low-speed hysteresis,
// safe reversal sequencing (decel -> brake -> restart) and latched stall fault.
module motor_cmd_supervisor
  import motor_pkg::*;
#(
  parameter int K_PWMRES   = 10,
  parameter int K_SPDWIDTH = 15,
  parameter int K_TMRWIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_time_base,
  input  logic                  i_enable,
  input  logic [K_PWMRES-1:0]   i_cmd_pwm,
  input  logic                  i_cmd_reverse,
  input  logic                  i_cmd_brake,
  input  logic                  i_fault_clear,
  input  logic [K_SPDWIDTH-1:0] i_speed,
  input  logic                  i_speed_valid,
  input  logic [K_PWMRES-1:0]   i_param_pwm_max,
  input  logic [K_PWMRES-1:0]   i_param_ramp_step,
  input  logic [K_SPDWIDTH-1:0] i_param_low_thr,
  input  logic [K_SPDWIDTH-1:0] i_param_low_hyst,
  input  logic [K_TMRWIDTH-1:0] i_param_brake_ticks,
  input  logic [K_TMRWIDTH-1:0] i_param_stall_ticks,
  output logic [K_PWMRES-1:0]   o_pwm_cmd,
  output logic                  o_reverse,
  output logic                  o_brake,
  output logic                  o_bypass_power,
  output logic                  o_stall_fault,
  output logic [2:0]            o_state
);

  state_t                state, state_nxt;
  logic                  reverse_nxt;
  logic                  take;
  logic                  stop_req;
  logic                  stall;
  logic                  hold_off;
  logic                  advance;
  logic [K_PWMRES-1:0]   target;
  logic [K_SPDWIDTH:0]   exit_lvl;
  logic [K_TMRWIDTH-1:0] brake_cnt;
  logic [K_TMRWIDTH-1:0] stall_cnt;

  assign stop_req = ~i_enable | i_cmd_brake;
  assign stall    = (i_param_stall_ticks != '0) && (stall_cnt == i_param_stall_ticks);
  assign exit_lvl = {1'b0, i_param_low_thr} + {1'b0, i_param_low_hyst};

  always_comb begin
    state_nxt   = state;
    reverse_nxt = o_reverse;
    case (state)
      ST_IDLE: if (~stop_req) begin
        state_nxt   = ST_RUN;
        reverse_nxt = i_cmd_reverse;
      end
      ST_RUN: begin
        if (stop_req)                        state_nxt = ST_BRAKE;
        else if (stall)                      state_nxt = ST_FAULT;
        else if (i_cmd_reverse != o_reverse) state_nxt = ST_DECEL;
      end
      ST_DECEL: if (stop_req || o_pwm_cmd == '0) state_nxt = ST_BRAKE;
      ST_BRAKE: if (brake_cnt >= i_param_brake_ticks && o_bypass_power) begin
        if (~stop_req) begin
          state_nxt   = ST_RUN;
          reverse_nxt = i_cmd_reverse;
        end else begin
          state_nxt   = ST_IDLE;
        end
      end
      ST_FAULT: if (i_fault_clear) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign take     = (state_nxt != state);
  assign hold_off = (state_nxt == ST_IDLE) || (state_nxt == ST_BRAKE) || (state_nxt == ST_FAULT);
  assign advance  = ~take && ((state == ST_RUN) || (state == ST_DECEL));
  assign target   = (state == ST_DECEL) ? '0 :
                    (i_cmd_pwm < i_param_pwm_max) ? i_cmd_pwm : i_param_pwm_max;

  pwm_ramp #(.K_RES(K_PWMRES)) u_ramp (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .tick       (i_time_base),
    .advance    (advance),
    .force_zero (hold_off),
    .step       (i_param_ramp_step),
    .target     (target),
    .value      (o_pwm_cmd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      o_reverse      <= 1'b0;
      o_brake        <= 1'b1;
      o_bypass_power <= 1'b1;
      o_stall_fault  <= 1'b0;
      brake_cnt      <= '0;
      stall_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      o_reverse     <= reverse_nxt;
      o_brake       <= hold_off;
      o_stall_fault <= (state_nxt == ST_FAULT);

      // A threshold sum beyond the speed range keeps the flag set forever.
      if (i_speed_valid) begin
        if (o_bypass_power && ({1'b0, i_speed} >= exit_lvl)) o_bypass_power <= 1'b0;
        else if (!o_bypass_power && (i_speed < i_param_low_thr)) o_bypass_power <= 1'b1;
      end

      if (state != ST_BRAKE || take) brake_cnt <= '0;
      else if (i_time_base && brake_cnt != '1) brake_cnt <= brake_cnt + 1'b1;

      if (state != ST_RUN || take || o_pwm_cmd == '0 || !o_bypass_power) stall_cnt <= '0;
      else if (i_time_base && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_motor_cmd_supervisor.sv
// Directed scoreboard bench for motor_cmd_supervisor.
module tb_motor_cmd_supervisor;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_time_base;
  logic        i_enable;
  logic [9:0]  i_cmd_pwm;
  logic        i_cmd_reverse;
  logic        i_cmd_brake;
  logic        i_fault_clear;
  logic [14:0] i_speed;
  logic        i_speed_valid;
  logic [9:0]  i_param_pwm_max;
  logic [9:0]  i_param_ramp_step;
  logic [14:0] i_param_low_thr;
  logic [14:0] i_param_low_hyst;
  logic [15:0] i_param_brake_ticks;
  logic [15:0] i_param_stall_ticks;
  logic [9:0]  o_pwm_cmd;
  logic        o_reverse;
  logic        o_brake;
  logic        o_bypass_power;
  logic        o_stall_fault;
  logic [2:0]  o_state;

  motor_cmd_supervisor dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_time_base         (i_time_base),
    .i_enable            (i_enable),
    .i_cmd_pwm           (i_cmd_pwm),
    .i_cmd_reverse       (i_cmd_reverse),
    .i_cmd_brake         (i_cmd_brake),
    .i_fault_clear       (i_fault_clear),
    .i_speed             (i_speed),
    .i_speed_valid       (i_speed_valid),
    .i_param_pwm_max     (i_param_pwm_max),
    .i_param_ramp_step   (i_param_ramp_step),
    .i_param_low_thr     (i_param_low_thr),
    .i_param_low_hyst    (i_param_low_hyst),
    .i_param_brake_ticks (i_param_brake_ticks),
    .i_param_stall_ticks (i_param_stall_ticks),
    .o_pwm_cmd           (o_pwm_cmd),
    .o_reverse           (o_reverse),
    .o_brake             (o_brake),
    .o_bypass_power      (o_bypass_power),
    .o_stall_fault       (o_stall_fault),
    .o_state             (o_state)
  );

  always #5 i_clk = ~i_clk;

  localparam int S_IDLE = 0, S_RUN = 1, S_DECEL = 2, S_BRAKE = 3, S_FAULT = 4;

  int sb_q[$];
  int passed = 0;
  int total  = 0;

  task automatic sb_push(input int v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag, input int obs);
    int exp;
    total++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick();
    i_time_base = 1'b1;
    cyc();
    i_time_base = 1'b0;
  endtask

  task automatic speed_sample(input int s);
    i_speed       = 15'(s);
    i_speed_valid = 1'b1;
    cyc();
    i_speed_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sp[4];
    int fl[4];
    sp = '{1100, 1199, 1200, 999};
    fl = '{1, 1, 0, 1};

    i_rst = 1'b1; i_time_base = 1'b0; i_enable = 1'b1; i_cmd_pwm = 10'd500;
    i_cmd_reverse = 1'b0; i_cmd_brake = 1'b0; i_fault_clear = 1'b0;
    i_speed = '0; i_speed_valid = 1'b0;
    i_param_pwm_max = 10'd1023; i_param_ramp_step = 10'd100;
    i_param_low_thr = 15'd1000; i_param_low_hyst = 15'd200;
    i_param_brake_ticks = 16'd3; i_param_stall_ticks = 16'd0;

    // Reset state
    sb_push(S_IDLE); sb_push(0); sb_push(1); sb_push(1); sb_push(0);
    cyc(); cyc();
    check("rst_state", o_state);
    check("rst_pwm", o_pwm_cmd);
    check("rst_brake", o_brake);
    check("rst_bypass", o_bypass_power);
    check("rst_fault", o_stall_fault);

    sb_push(S_RUN); sb_push(0);
    i_rst = 1'b0;
    cyc();
    check("idle_to_run", o_state);
    check("run_brake", o_brake);

    // Ramp up and down
    for (int i = 1; i <= 5; i++) begin
      sb_push(i * 100);
      tick();
      check("ramp_up", o_pwm_cmd);
    end
    i_cmd_pwm = 10'd250;
    sb_push(400); tick(); check("ramp_dn1", o_pwm_cmd);
    sb_push(300); tick(); check("ramp_dn2", o_pwm_cmd);
    sb_push(250); tick(); check("ramp_dn3", o_pwm_cmd);

    // Clamp with immediate step
    i_param_pwm_max = 10'd300; i_cmd_pwm = 10'd1000; i_param_ramp_step = 10'd0;
    sb_push(300);
    cyc();
    check("clamp_immediate", o_pwm_cmd);

    // Hysteresis
    for (int i = 0; i < 4; i++) begin
      sb_push(fl[i]);
      speed_sample(sp[i]);
      check("hyst_flag", o_bypass_power);
    end

    // Reversal: DECEL -> BRAKE -> RUN
    i_param_pwm_max = 10'd1023; i_cmd_pwm = 10'd200; i_param_ramp_step = 10'd50;
    tick(); tick();
    sb_push(200); check("pre_rev_pwm", o_pwm_cmd);
    i_cmd_reverse = 1'b1;
    sb_push(S_DECEL); sb_push(200);
    cyc();
    check("rev_decel", o_state);
    check("decel_hold_pwm", o_pwm_cmd);
    for (int i = 3; i >= 0; i--) begin
      sb_push(i * 50);
      tick();
      check("decel_ramp", o_pwm_cmd);
    end
    sb_push(S_BRAKE); sb_push(1);
    cyc();
    check("decel_to_brake", o_state);
    check("brake_out", o_brake);
    tick(); tick();
    sb_push(S_BRAKE); cyc(); check("brake_min_time", o_state);
    speed_sample(1500);
    tick();
    sb_push(S_BRAKE); cyc(); check("brake_wait_bypass", o_state);
    speed_sample(500);
    sb_push(S_RUN); sb_push(1); sb_push(0);
    cyc();
    check("brake_to_run", o_state);
    check("run_reversed", o_reverse);
    check("run_unbraked", o_brake);

    // Stall fault
    i_param_ramp_step = 10'd0; i_cmd_pwm = 10'd100; i_param_stall_ticks = 16'd5;
    sb_push(100); cyc(); check("stall_pwm", o_pwm_cmd);
    for (int i = 0; i < 4; i++) tick();
    sb_push(S_RUN); check("stall_not_yet", o_state);
    tick();
    sb_push(S_FAULT); sb_push(1); sb_push(0); sb_push(1);
    cyc();
    check("stall_fault_state", o_state);
    check("stall_fault_flag", o_stall_fault);
    check("fault_pwm", o_pwm_cmd);
    check("fault_brake", o_brake);
    i_fault_clear = 1'b1;
    sb_push(S_IDLE); sb_push(0);
    cyc();
    i_fault_clear = 1'b0;
    check("fault_clear_idle", o_state);
    check("fault_cleared", o_stall_fault);

    // Stall detection disabled
    i_param_stall_ticks = 16'd0;
    cyc(); cyc();
    for (int i = 0; i < 8; i++) tick();
    sb_push(S_RUN); sb_push(0); sb_push(100);
    cyc();
    check("stall_off_state", o_state);
    check("stall_off_fault", o_stall_fault);
    check("stall_off_pwm", o_pwm_cmd);

    // Brake wins over reversal
    i_cmd_brake = 1'b1; i_cmd_reverse = 1'b0;
    sb_push(S_BRAKE); sb_push(0);
    cyc();
    check("brake_priority", o_state);
    check("brake_pwm0", o_pwm_cmd);

    // Reset during BRAKE
    i_cmd_brake = 1'b0;
    tick();
    i_rst = 1'b1;
    sb_push(S_IDLE); sb_push(0); sb_push(1); sb_push(0);
    cyc();
    check("midrst_state", o_state);
    check("midrst_reverse", o_reverse);
    check("midrst_brake", o_brake);
    check("midrst_pwm", o_pwm_cmd);
    i_rst = 1'b0;
    sb_push(S_RUN); sb_push(0);
    cyc();
    check("post_rst_run", o_state);
    check("post_rst_reverse", o_reverse);

    total++;
    assert (sb_q.size() == 0) passed++;
    else $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
